// File: rtl/cdf_lut_gen.sv
// cdf_lut_gen: builds a 256-entry histogram-equalisation LUT from a
// histogram, one bin per 12 cycles; optional bin clear (CDFLUT_HIST_CLEAR_EN).
// Ports: clk, reset_n, start, total_pixels, hist_rd_en/addr/data,
// hist_clr_we (macro only), busy, done, lut_rd_addr, lut_rd_data.
module cdf_lut_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] total_pixels,
  output logic        hist_rd_en,
  output logic [7:0]  hist_rd_addr,
  input  logic [31:0] hist_rd_data,
`ifdef CDFLUT_HIST_CLEAR_EN
  output logic        hist_clr_we,
`endif
  output logic        busy,
  output logic        done,
  input  logic [7:0]  lut_rd_addr,
  output logic [7:0]  lut_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_ACC, S_DIV, S_WR, S_FIN
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  k;
  logic [31:0] n_q;
  logic [31:0] cnt_q;
  logic [31:0] cdf;
  logic [31:0] cdf_min;
  logic        min_found;
  logic [39:0] rem;
  logic [31:0] dsr;
  logic [7:0]  quo;
  logic [2:0]  it;
  logic [7:0]  lut_mem [256];

  // values the bin accumulation produces, used to seed the divider
  logic [31:0] cdf_nx;
  logic        min_hit;
  logic [31:0] min_nx;
  logic [31:0] den_nx;
  logic [39:0] num_nx;
  logic [39:0] trial;
  logic        ge;
  logic [7:0]  wr_val;

  always_comb begin
    cdf_nx  = cdf + cnt_q;
    min_hit = !min_found && (cnt_q != 32'd0);
    min_nx  = min_hit ? cnt_q : cdf_min;
    den_nx  = n_q - min_nx;
    num_nx  = {8'd0, cdf_nx - min_nx} * 40'd255
            + {8'd0, den_nx >> 1};
  end

  // one restoring step per cycle, MSB of quotient first
  assign trial = {8'd0, dsr} << it;
  assign ge    = rem >= trial;

  always_comb begin
    if (!min_found)
      wr_val = 8'd0;
    else if (dsr == 32'd0)
      wr_val = k;
    else if (cdf > n_q)
      wr_val = 8'd255;
    else
      wr_val = quo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_RD;
      S_RD:   state_nx = S_WAIT;
      S_WAIT: state_nx = S_ACC;
      S_ACC:  state_nx = S_DIV;
      S_DIV:  if (it == 3'd0) state_nx = S_WR;
      S_WR:   state_nx = (k == 8'd255) ? S_FIN : S_RD;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    hist_rd_en = 1'b0;
`ifdef CDFLUT_HIST_CLEAR_EN
    hist_clr_we = 1'b0;
`endif
    unique case (state)
      S_IDLE: ;
      S_RD: begin
        busy       = 1'b1;
        hist_rd_en = 1'b1;
      end
      S_ACC: begin
        busy = 1'b1;
`ifdef CDFLUT_HIST_CLEAR_EN
        hist_clr_we = 1'b1;
`endif
      end
      S_WAIT, S_DIV, S_WR: busy = 1'b1;
      S_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign hist_rd_addr = k;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k         <= 8'd0;
      n_q       <= 32'd0;
      cnt_q     <= 32'd0;
      cdf       <= 32'd0;
      cdf_min   <= 32'd0;
      min_found <= 1'b0;
      rem       <= 40'd0;
      dsr       <= 32'd0;
      quo       <= 8'd0;
      it        <= 3'd0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          k         <= 8'd0;
          cdf       <= 32'd0;
          cdf_min   <= 32'd0;
          min_found <= 1'b0;
          n_q       <= total_pixels;
        end
        S_WAIT: cnt_q <= hist_rd_data;
        S_ACC: begin
          cdf       <= cdf_nx;
          cdf_min   <= min_nx;
          min_found <= min_found | min_hit;
          rem       <= num_nx;
          dsr       <= den_nx;
          quo       <= 8'd0;
          it        <= 3'd7;
        end
        S_DIV: begin
          if (ge) rem <= rem - trial;
          quo <= {quo[6:0], ge};
          it  <= it - 3'd1;
        end
        // wraps to 0 after the last bin
        S_WR: k <= k + 8'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WR)
      lut_mem[k] <= wr_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lut_rd_data <= 8'd0;
    else
      lut_rd_data <= lut_mem[lut_rd_addr];
  end

endmodule

// File: tb/tb_cdf_lut_gen.sv
// tb_cdf_lut_gen: directed checks of cdf_lut_gen LUT contents, timing,
// start masking, mid-build reset and optional histogram clear.
module tb_cdf_lut_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] total_pixels;
  logic        hist_rd_en;
  logic [7:0]  hist_rd_addr;
  logic [31:0] hist_rd_data;
  logic        busy;
  logic        done;
  logic [7:0]  lut_rd_addr;
  logic [7:0]  lut_rd_data;
`ifdef CDFLUT_HIST_CLEAR_EN
  logic        hist_clr_we;
  localparam logic [31:0] HIST_AFTER = 32'd0;
`else
  localparam logic [31:0] HIST_AFTER = 32'd1;
`endif

  cdf_lut_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .total_pixels (total_pixels),
    .hist_rd_en   (hist_rd_en),
    .hist_rd_addr (hist_rd_addr),
    .hist_rd_data (hist_rd_data),
`ifdef CDFLUT_HIST_CLEAR_EN
    .hist_clr_we  (hist_clr_we),
`endif
    .busy         (busy),
    .done         (done),
    .lut_rd_addr  (lut_rd_addr),
    .lut_rd_data  (lut_rd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] hist [256];
  logic [31:0] hist_q = 32'd0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [31:0] ld_val = 32'd0;

  always @(posedge clk) begin
    if (ld_en) hist[ld_addr] <= ld_val;
    if (hist_rd_en) hist_q <= hist[hist_rd_addr];
`ifdef CDFLUT_HIST_CLEAR_EN
    if (hist_clr_we) hist[hist_rd_addr] <= 32'd0;
`endif
  end
  assign hist_rd_data = hist_q;

  typedef struct {
    int         tc;
    int         lo;
    int         hi;
    bit         ident;
    logic [7:0] val;
  } lut_vec_t;

  lut_vec_t tbl [7];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // 0: all ones, 1: bins 10/200 = 50, 2: bin 77 = 64, 3: bins 0..2 = 1
  task automatic load_hist(input int mode);
    for (int i = 0; i < 256; i++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(i);
      case (mode)
        0: ld_val = 32'd1;
        1: ld_val = (i == 10 || i == 200) ? 32'd50 : 32'd0;
        2: ld_val = (i == 77) ? 32'd64 : 32'd0;
        default: ld_val = (i < 3) ? 32'd1 : 32'd0;
      endcase
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic read_lut(input int a, output logic [7:0] d);
    lut_rd_addr = 8'(a);
    @(posedge clk); #1;
    d = lut_rd_data;
  endtask

  task automatic check_lut(input int tc, input string nm);
    logic [7:0] d;
    logic [7:0] e;
    for (int r = 0; r < 7; r++) begin
      if (tbl[r].tc == tc) begin
        for (int a = tbl[r].lo; a <= tbl[r].hi; a++) begin
          read_lut(a, d);
          e = tbl[r].ident ? 8'(a) : tbl[r].val;
          chk($sformatf("%s lut[%0d]", nm, a), {24'd0, d}, {24'd0, e});
        end
      end
    end
  endtask

  // start accepted at the edge closing cycle 0; extra >0 re-pulses start
  task automatic run_frame(input logic [31:0] n, input int extra,
                           input string nm);
    int done_cyc = -1;
    int done_cnt = 0;
    int busy_bad = 0;
    start        = 1'b1;
    total_pixels = n;
    @(posedge clk); #1;
    start        = 1'b0;
    total_pixels = 32'h0000_1234;
    for (int c = 1; c <= 3100; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== (c <= 3072)) busy_bad++;
      start = (c == extra);
    end
    start = 1'b0;
    chk({nm, " done cycle"}, 32'(done_cyc), 32'd3073);
    chk({nm, " done count"}, 32'(done_cnt), 32'd1);
    chk({nm, " busy errs"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    tbl[0] = '{0, 0,   255, 1'b1, 8'd0};
    tbl[1] = '{1, 0,   199, 1'b0, 8'd0};
    tbl[2] = '{1, 200, 255, 1'b0, 8'd255};
    tbl[3] = '{2, 0,   76,  1'b0, 8'd0};
    tbl[4] = '{2, 77,  255, 1'b1, 8'd0};
    tbl[5] = '{3, 0,   0,   1'b0, 8'd0};
    tbl[6] = '{3, 1,   1,   1'b0, 8'd128};
  end

  initial begin
    logic [7:0] d;
    reset_n      = 1'b0;
    start        = 1'b0;
    total_pixels = 32'd0;
    lut_rd_addr  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst rd_en", {31'd0, hist_rd_en}, 32'd0);
    chk("rst rd_addr", {24'd0, hist_rd_addr}, 32'd0);
    chk("rst lut_rd", {24'd0, lut_rd_data}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    load_hist(0);
    run_frame(32'd256, -1, "ramp");
    check_lut(0, "ramp");
    for (int i = 0; i < 256; i++)
      chk($sformatf("hist[%0d] after", i), hist[i], HIST_AFTER);

    load_hist(1);
    run_frame(32'd100, -1, "two");
    check_lut(1, "two");

    load_hist(2);
    run_frame(32'd64, -1, "den0");
    check_lut(2, "den0");

    load_hist(3);
    run_frame(32'd3, 500, "tiny");
    check_lut(3, "tiny");
    for (int a = 2; a < 256; a++) begin
      read_lut(a, d);
      chk($sformatf("tiny lut[%0d]", a), {24'd0, d}, 32'd255);
    end

    load_hist(0);
    start        = 1'b1;
    total_pixels = 32'd256;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c <= 1205; c++) begin
      @(posedge clk); #1;
      if (c == 1201) begin
        chk("k100 rd_en", {31'd0, hist_rd_en}, 32'd1);
        chk("k100 addr", {24'd0, hist_rd_addr}, 32'd100);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort rd_en", {31'd0, hist_rd_en}, 32'd0);
    chk("abort addr", {24'd0, hist_rd_addr}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    load_hist(0);
    run_frame(32'd256, -1, "rebuild");
    check_lut(0, "rebuild");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
